// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 8N1, LSB first, idle-high line, sampled with an
// oversampling clock enable. A received byte is held in rx_data until the
// consumer reads it. Framing errors and overruns are reported as one-clk
// pulses.
module midi_uart_rx #(
    parameter int OS_RATE     = 16,  // enable pulses per bit; power of two, >= 4
    parameter int SYNC_STAGES = 2    // rxd synchronizer depth, >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       os_en,
    input  logic       rxd,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_err,
    output logic       overrun
);

    localparam int TW = $clog2(OS_RATE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OS_RATE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          framing_err_q, framing_err_d;
    logic          overrun_q, overrun_d;

    // Synchronize the asynchronous line; reset to the idle (high) level so a
    // reset never looks like a start bit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, exactly like hardware.
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // Next-state logic: frame FSM advances on enables, handshake on every clk.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d       = state_q;
        tick_d        = tick_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q & ~rx_rd;
        framing_err_d = 1'b0;
        overrun_d     = 1'b0;

        if (os_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end

                // Re-check the line half a bit in to reject short glitches.
                S_START: begin
                    if (tick_q == HALF_LAST) begin
                        if (rxs) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (tick_q == FULL_LAST) begin
                        shift_d = {rxs, shift_q[7:1]};
                        tick_d  = '0;
                        if (bit_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                // A read on the completion edge frees the holding register in
                // time, so the new byte loads instead of being dropped.
                S_STOP: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d = '0;
                        if (rxs) begin
                            state_d = S_IDLE;
                            if (!rx_valid_q || rx_rd) begin
                                rx_data_d  = shift_q;
                                rx_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            framing_err_d = 1'b1;
                            state_d       = S_BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                // Held-low line: wait for idle so a break reports only once.
                S_BREAK: begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tick_q        <= '0;
            bit_q         <= '0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            bit_q         <= bit_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    // Data shift register.
    always_ff @(posedge clk) begin
        // NOTE: no reset here on purpose; all eight bits are rewritten by
        // every frame before the stop sample can copy them out.
        shift_q <= shift_d;
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

endmodule
